// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the asynchronous FIFO read side.
package fifo_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   typedef logic [1:0] occ_t;
   localparam occ_t CNT_MAX = 2'd2;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: two-entry head/skid register pair with occupancy count.
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int W = DEF_DATA_WIDTH
) (
   input  logic         rclk,
   input  logic         rrst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] in_data,
   output occ_t         cnt,
   output logic         out_valid,
   output logic [W-1:0] out_data
);
   logic [W-1:0] skid, head_nxt, skid_nxt;
   occ_t cnt_nxt;
   assign out_valid = cnt != '0;
   // The head is reloaded from rdata when empty or when a word leaves as a new one arrives;
   // otherwise the skid word moves up so order is preserved.
   always_comb begin
      cnt_nxt  = flush ? '0 : occ_t'(cnt + occ_t'(push) - occ_t'(pop));
      head_nxt = flush ? out_data :
                 (push & (cnt == '0 | pop)) ? in_data :
                 (pop & cnt == CNT_MAX) ? skid : out_data;
      skid_nxt = (~flush & push & ~pop & cnt == occ_t'(1)) ? in_data : skid;
   end
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         cnt      <= '0;
         out_data <= '0;
         skid     <= '0;
      end else begin
         cnt      <= cnt_nxt;
         out_data <= head_nxt;
         skid     <= skid_nxt;
      end
   end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read side to valid/ready stream with a two-word skid buffer.
// Optional even parity output (out_par) when FIFO_RD_STREAM_PARITY_EN is defined.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  rempty,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic                  flush,
   output logic                  rinc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_RD_STREAM_PARITY_EN
   ,
   output logic                  out_par
`endif
);
`ifdef FIFO_RD_STREAM_PARITY_EN
   localparam int W = DATA_WIDTH + 1;
   logic [W-1:0] in_word, head;
   assign in_word = {^rdata, rdata};
   assign {out_par, out_data} = head;
`else
   localparam int W = DATA_WIDTH;
   logic [W-1:0] in_word, head;
   assign in_word  = rdata;
   assign out_data = head;
`endif
   occ_t cnt;
   logic pop;
   // Built only from registered signals, so no loop through the read-pointer block.
   assign rinc = ~rempty & (cnt < CNT_MAX) & ~flush;
   assign pop  = out_valid & out_ready;
   fifo_rd_skid #(.W(W)) skid_i (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .push      (rinc),
      .pop       (pop),
      .flush     (flush),
      .in_data   (in_word),
      .cnt       (cnt),
      .out_valid (out_valid),
      .out_data  (head)
   );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: queue-model self-checking bench for fifo_rd_stream.
module tb_fifo_rd_stream;
   logic       rclk = 0, rrst_n = 0, rempty = 1, flush = 0, out_ready = 0;
   logic [7:0] rdata = 0, out_data;
   logic       rinc, out_valid;
`ifdef FIFO_RD_STREAM_PARITY_EN
   logic       out_par;
`endif
   int checks = 0, failures = 0, npop = 0;
   logic [7:0] src[$], mbuf[$], acc[$];
   logic exp_rinc = 0, exp_pop = 0, check_on = 0;

   always #5 rclk = ~rclk;

   fifo_rd_stream dut (
      .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .flush(flush),
      .rinc(rinc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef FIFO_RD_STREAM_PARITY_EN
      , .out_par(out_par)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge rclk) if (check_on) begin
      chk("rinc", {31'd0, rinc}, {31'd0, exp_rinc});
      chk("out_valid", {31'd0, out_valid}, {31'd0, mbuf.size() != 0});
      if (mbuf.size() != 0) begin
         chk("out_data", {24'd0, out_data}, {24'd0, mbuf[0]});
`ifdef FIFO_RD_STREAM_PARITY_EN
         chk("out_par", {31'd0, out_par}, {31'd0, ^mbuf[0]});
`endif
      end
   end

   // Drive one cycle from the source queue and advance the buffer model at the edge.
   task automatic cyc();
      rempty   = src.size() == 0;
      rdata    = src.size() != 0 ? src[0] : 8'h00;
      exp_rinc = !rempty && mbuf.size() < 2 && !flush;
      exp_pop  = !flush && mbuf.size() != 0 && out_ready;
      @(posedge rclk);
      if (flush) mbuf.delete();
      else begin
         if (exp_pop) acc.push_back(mbuf.pop_front());
         if (exp_rinc) begin
            mbuf.push_back(src.pop_front());
            npop++;
         end
      end
      #1;
   endtask

   initial begin
      #2;
      chk("reset_rinc", {31'd0, rinc}, 0);
      chk("reset_valid", {31'd0, out_valid}, 0);
      chk("reset_data", {24'd0, out_data}, 0);
`ifdef FIFO_RD_STREAM_PARITY_EN
      chk("reset_par", {31'd0, out_par}, 0);
`endif
      repeat (2) @(posedge rclk);
      #1 rrst_n = 1;
      check_on = 1;
      // single word
      out_ready = 1;
      npop = 0;
      src.push_back(8'hA5);
      cyc();
      chk("single_valid", {31'd0, out_valid}, 1);
      chk("single_data", {24'd0, out_data}, 32'hA5);
      cyc();
      chk("single_done", {31'd0, out_valid}, 0);
      chk("single_pops", npop, 1);
      // streaming
      acc.delete();
      npop = 0;
      for (int i = 1; i <= 16; i++) src.push_back(8'(i));
      repeat (18) cyc();
      chk("stream_count", acc.size(), 16);
      for (int i = 0; i < 16 && i < acc.size(); i++) chk("stream_order", {24'd0, acc[i]}, i + 1);
      // back-pressure
      out_ready = 0;
      npop = 0;
      src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33);
      repeat (4) cyc();
      chk("bp_pops", npop, 2);
      chk("bp_hold", {24'd0, out_data}, 32'h11);
      chk("bp_rinc", {31'd0, rinc}, 0);
      out_ready = 1;
      acc.delete();
      repeat (3) cyc();
      chk("bp_count", acc.size(), 3);
      if (acc.size() == 3) begin
         chk("bp_0", {24'd0, acc[0]}, 32'h11);
         chk("bp_1", {24'd0, acc[1]}, 32'h22);
         chk("bp_2", {24'd0, acc[2]}, 32'h33);
      end
      // flush at cnt=2
      out_ready = 0;
      src.push_back(8'h55); src.push_back(8'h66);
      repeat (3) cyc();
      flush = 1;
      src.push_back(8'h44);
      cyc();
      flush = 0;
      chk("flush_valid", {31'd0, out_valid}, 0);
      out_ready = 1;
      cyc();
      chk("flush_next", {24'd0, out_data}, 32'h44);
      repeat (2) cyc();
`ifdef FIFO_RD_STREAM_PARITY_EN
      out_ready = 0;
      src.push_back(8'h07); src.push_back(8'h03); src.push_back(8'h05);
      repeat (3) cyc();
      chk("par_07", {31'd0, out_par}, 1);
      out_ready = 1;
      cyc();
      chk("par_03_skid", {31'd0, out_par}, 0);
      repeat (3) cyc();
`endif
      // asynchronous reset mid-operation
      out_ready = 0;
      src.push_back(8'h12); src.push_back(8'h34);
      repeat (2) cyc();
      #2 rrst_n = 0;
      #1;
      check_on = 0;
      chk("async_valid", {31'd0, out_valid}, 0);
      chk("async_data", {24'd0, out_data}, 0);
      mbuf.delete();
      src.delete();
      @(posedge rclk);
      #1 rrst_n = 1;
      check_on = 1;
      src.push_back(8'h9C);
      out_ready = 1;
      repeat (3) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
